flash_prog: RTL and testbench
=============================

# flash_prog

Wishbone-slave programming engine for the board's parallel NOR flash, the write-side companion of the read-only flash port. Software loads a target address and data word through four registers, then issues a program or sector-erase command. The block generates the AMD/JEDEC unlock command sequence with timed WE pulses, and data-polls DQ7/DQ5 until the operation completes, fails or times out. While it is active, `busy_o` tells the external pad mux to hand the flash pins to this block.

## Interface
Parameters:
- `WE_CYCLES`, 4: clocks that WE# is held low per bus write; minimum 1.
- `RD_CYCLES`, 4: clocks that OE# is held low per poll read; the data pins are sampled on the last clock.
- `TO_BITS`, 24: width of the timeout counter; the timeout is 2^TO_BITS−1 poll reads.

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset; synchronous, active-high
- `wb_dat_i`  in  16  write data
- `wb_dat_o`  out  16  read data
- `wb_adr_i`  in  [2:1]  register select
- `wb_we_i`, `wb_stb_i`, `wb_cyc_i`  in  1  Wishbone controls
- `wb_sel_i`  in  2  byte selects; ignored, all accesses are 16-bit
- `wb_ack_o`  out  1  acknowledge
- `busy_o`  out  1  engine owns the flash pins
- `flash_addr_`  out  22  flash word address [22:1]
- `flash_data_i`  in  16  flash data from pad
- `flash_data_o`  out  16  flash data to pad
- `flash_data_oe`  out  1  drive enable for `flash_data_o`
- `flash_we_n_`, `flash_oe_n_`, `flash_ce_n_`, `flash_rst_n_`  out  1  flash strobes

## Operation
Registers, selected by `wb_adr_i`:
- 0 ADDR_LO: target address [16:1].
- 1 ADDR_HI: bits [5:0] hold target address [22:17].
- 2 DATA: program data.
- 3 CMD/STATUS.
  - Write: bit0 = PROGRAM, bit1 = ERASE. If both bits are set, PROGRAM wins. A write with neither bit set has no effect.
  - Read: bit0 = busy, bit1 = error, bit2 = timeout, bit3 = done. Other bits read 0.
- Issuing a command clears error, timeout and done.
- While busy, writes to registers 0–3 are acked but ignored.

Command sequences (address/data per bus write):
- PROGRAM: 555/AA, 2AA/55, 555/A0, ADDR/DATA.
- ERASE: 555/AA, 2AA/55, 555/80, 555/AA, 2AA/55, ADDR/0030.

State machine: IDLE → W_SETUP → W_PULSE → W_HOLD, repeated for each step of the sequence → P_READ → P_GAP → back to P_READ, or to IDLE.
- W_SETUP, 1 clk: CE# low, address and data driven, `flash_data_oe`=1, WE# high.
- W_PULSE, WE_CYCLES clks: WE# low.
- W_HOLD, 1 clk: WE# high, data still driven. Then the next step, or P_READ after the last step.
- P_READ, RD_CYCLES clks: `flash_data_oe`=0, CE# and OE# low, address = ADDR. On the last clock, sample `flash_data_i` as Q.
- P_GAP, 1 clk: OE# high. Then decide:
  - Done if Q[7] equals the expected value (DATA[7] for program, 1 for erase). Set done and go to IDLE.
  - Otherwise, if Q[5]=1: one more read is required. If its Q[7] matches, set done; if not, set error. Go to IDLE.
  - Otherwise, increment the timeout counter. When it reaches its maximum, set timeout and error and go to IDLE; else return to P_READ.

Other behaviour:
- `busy_o` = 1 in every state except IDLE.
- In IDLE, all flash strobes are high and `flash_data_oe`=0.
- `wb_dat_o` is registered; it is loaded with the selected register on the same edge that asserts ack.
- `flash_rst_n_` is registered: 0 while `wb_rst_i` is high, then 1.

## Timing
- Ack: `wb_ack_o <= wb_rst_i ? 0 : (wb_ack_o ? 0 : stb&cyc)`. Every access gets exactly one ack, one clock after the strobe, and ack is never high on two consecutive clocks.
- Start: the command write is captured on the acking edge; W_SETUP begins on the next clock.
- Program latency to the first poll: 4×(WE_CYCLES+2) clocks.
- Reset mid-operation: on the next edge the FSM is in IDLE, WE#/OE#/CE# are 1 and `flash_data_oe`=0. Reset values are 0 for ADDR, DATA, status, `wb_ack_o`, `busy_o` and `wb_dat_o`.

## Configuration
- `FLASH_PROG_ERASE_EN` defined: the ERASE command is implemented as specified above.
- Not defined: CMD bit1 is ignored. ERASE-only writes have no effect, and the erase sequence logic and its states are not synthesised.

## Structure
- Shared package `flash_pkg`:
  - FSM state enum.
  - Unlock constants: UNLOCK1_ADDR=555, UNLOCK2_ADDR=2AA, AA, 55, A0, 80, 30.
  - Register indices.
  - Status bit positions.
- Sub-module `flash_seq_rom`: a combinational table mapping (command, step) to the address and data for that bus write, plus a last-step flag.

## Test plan
- Program: ADDR=0x012345, DATA=0xBEEF, CMD=1. Expect the four writes 555/AA, 2AA/55, 555/A0, 012345/BEEF, each with WE# low for exactly 4 clocks. The flash model returns BEEF on the 3rd poll. Then status = 0x0008 and `busy_o` falls.
- Erase (macro defined): ADDR=0x200000, CMD=2. Expect six writes ending 200000/0030. The model returns Q[7]=0 for 10 polls, then 1. Then status = done.
- DQ5 failure: the model holds Q[7]≠DATA[7] with Q[5]=1. Expect exactly one extra read, then status = 0x0002 (error).
- Timeout (TO_BITS=4): the model never completes. Expect 15 polls, then status = 0x0006.
- Busy lockout: write DATA=0x1111 during a program. Expect the write acked, DATA unchanged, and a simultaneous CMD=3 write ignored.
- Reset: assert `wb_rst_i` during W_PULSE. On the next edge expect WE#=1, `flash_data_oe`=0, `busy_o`=0 and `flash_rst_n_`=0.

Source files
------------

// File: rtl/flash_pkg.sv
// Shared definitions for the NOR flash programming engine.
//   - FSM state encoding
//   - AMD/JEDEC unlock addresses and command words
//   - Wishbone register indices and status bit positions
package flash_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_P_READ,
    S_P_GAP
  } state_t;

  typedef enum logic {
    OP_PROG,
    OP_ERASE
  } op_t;

  localparam logic [21:0] UNLOCK1_ADDR = 22'h000555;
  localparam logic [21:0] UNLOCK2_ADDR = 22'h0002AA;

  localparam logic [15:0] CMD_AA = 16'h00AA;
  localparam logic [15:0] CMD_55 = 16'h0055;
  localparam logic [15:0] CMD_A0 = 16'h00A0;
  localparam logic [15:0] CMD_80 = 16'h0080;
  localparam logic [15:0] CMD_30 = 16'h0030;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_CMD     = 2'd3;

  localparam int ST_BUSY = 0;
  localparam int ST_ERR  = 1;
  localparam int ST_TO   = 2;
  localparam int ST_DONE = 3;

endpackage

// File: rtl/flash_seq_rom.sv
// Command sequence table: maps (command, step) to the address/data of that
// flash bus write and flags the final step of the sequence.
//   op      : command being run (present only with FLASH_PROG_ERASE_EN)
//   step    : index of the bus write within the sequence
//   addr    : target word address, used by the final step
//   data    : program data, used by the final program step
//   wr_addr : address for this bus write
//   wr_data : data for this bus write
//   last    : this is the final bus write of the sequence
// Macro FLASH_PROG_ERASE_EN adds the six-step sector-erase sequence.
module flash_seq_rom
  import flash_pkg::*;
(
`ifdef FLASH_PROG_ERASE_EN
  input  op_t         op,
`endif
  input  logic [2:0]  step,
  input  logic [21:0] addr,
  input  logic [15:0] data,
  output logic [21:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        last
);

  always_comb begin
    wr_addr = UNLOCK1_ADDR;
    wr_data = CMD_AA;
    last    = 1'b0;
`ifdef FLASH_PROG_ERASE_EN
    if (op == OP_ERASE) begin
      case (step)
        3'd0: ;
        3'd1: begin wr_addr = UNLOCK2_ADDR; wr_data = CMD_55; end
        3'd2: wr_data = CMD_80;
        3'd3: ;
        3'd4: begin wr_addr = UNLOCK2_ADDR; wr_data = CMD_55; end
        default: begin wr_addr = addr; wr_data = CMD_30; last = 1'b1; end
      endcase
    end else
`endif
    begin
      case (step)
        3'd0: ;
        3'd1: begin wr_addr = UNLOCK2_ADDR; wr_data = CMD_55; end
        3'd2: wr_data = CMD_A0;
        default: begin wr_addr = addr; wr_data = data; last = 1'b1; end
      endcase
    end
  end

endmodule

// File: rtl/flash_prog.sv
// Wishbone-slave programming engine for a parallel NOR flash.
// Software loads address/data registers, then writes CMD to run the unlock
// sequence with timed WE# pulses and data-poll DQ7/DQ5 until the operation
// completes, fails or times out.
//   wb_*          : Wishbone slave (16-bit, 4 registers on wb_adr_i[2:1])
//   busy_o        : engine owns the flash pins (pad mux select)
//   flash_*       : flash address/data/strobes, flash_data_oe drives the pads
// Parameters: WE_CYCLES (WE# low clocks), RD_CYCLES (OE# low clocks per
// poll), TO_BITS (timeout counter width, 2^TO_BITS-1 polls).
// Macro FLASH_PROG_ERASE_EN enables the sector-erase command (CMD bit1).
module flash_prog
  import flash_pkg::*;
#(
  parameter int WE_CYCLES = 4,
  parameter int RD_CYCLES = 4,
  parameter int TO_BITS   = 24
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [2:1]  wb_adr_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [1:0]  wb_sel_i,
  output logic        wb_ack_o,
  output logic        busy_o,
  output logic [22:1] flash_addr_,
  input  logic [15:0] flash_data_i,
  output logic [15:0] flash_data_o,
  output logic        flash_data_oe,
  output logic        flash_we_n_,
  output logic        flash_oe_n_,
  output logic        flash_ce_n_,
  output logic        flash_rst_n_
);

  localparam int CW = 16;
  localparam logic [CW-1:0] WE_LAST = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);
  // one below all-ones: the increment that would reach the maximum
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  state_t state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2:0]         step;
  logic [21:0]        addr_r;
  logic [15:0]        data_r;
  logic               st_err, st_to, st_done;
  logic               q7, q5, extra;
  logic [TO_BITS-1:0] to_cnt;
  logic [21:0]        rom_addr;
  logic [15:0]        rom_data;
  logic               rom_last;
  logic               access, busy, wr_ok, start, exp7;
  logic               fin_done, fin_err, fin_to, retry, to_inc;
  logic [15:0]        rd_mux;
  logic               unused_ok;

  assign unused_ok = ^{wb_sel_i, flash_data_i[15:8], flash_data_i[6], flash_data_i[4:0]};

  assign access = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign busy   = (state != S_IDLE);
  assign busy_o = busy;
  assign wr_ok  = access & wb_we_i & ~busy;

`ifdef FLASH_PROG_ERASE_EN
  op_t op;
  assign start = wr_ok && (wb_adr_i == REG_CMD) && (wb_dat_i[0] || wb_dat_i[1]);
  assign exp7  = (op == OP_ERASE) ? 1'b1 : data_r[7];
  flash_seq_rom u_rom (
    .op(op), .step(step), .addr(addr_r), .data(data_r),
    .wr_addr(rom_addr), .wr_data(rom_data), .last(rom_last)
  );
`else
  assign start = wr_ok && (wb_adr_i == REG_CMD) && wb_dat_i[0];
  assign exp7  = data_r[7];
  flash_seq_rom u_rom (
    .step(step), .addr(addr_r), .data(data_r),
    .wr_addr(rom_addr), .wr_data(rom_data), .last(rom_last)
  );
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    fin_done = 1'b0;
    fin_err  = 1'b0;
    fin_to   = 1'b0;
    retry    = 1'b0;
    to_inc   = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nx = S_W_SETUP;
      S_W_SETUP: state_nx = S_W_PULSE;
      S_W_PULSE: if (cnt == WE_LAST) state_nx = S_W_HOLD;
      S_W_HOLD:  state_nx = rom_last ? S_P_READ : S_W_SETUP;
      S_P_READ:  if (cnt == RD_LAST) state_nx = S_P_GAP;
      S_P_GAP: begin
        state_nx = S_IDLE;
        if (q7 == exp7) fin_done = 1'b1;
        else if (extra) fin_err = 1'b1;        // DQ5 confirm read still wrong
        else if (q5) begin retry = 1'b1; state_nx = S_P_READ; end
        else if (to_cnt == TO_LAST) begin fin_to = 1'b1; fin_err = 1'b1; end
        else begin to_inc = 1'b1; state_nx = S_P_READ; end
      end
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = 16'h0000;
    case (wb_adr_i)
      REG_ADDR_LO: rd_mux = addr_r[15:0];
      REG_ADDR_HI: rd_mux = {10'b0, addr_r[21:16]};
      REG_DATA:    rd_mux = data_r;
      default: begin
        rd_mux[ST_BUSY] = busy;
        rd_mux[ST_ERR]  = st_err;
        rd_mux[ST_TO]   = st_to;
        rd_mux[ST_DONE] = st_done;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= 16'h0000;
      flash_rst_n_ <= 1'b0;
      addr_r       <= '0;
      data_r       <= '0;
      st_err       <= 1'b0;
      st_to        <= 1'b0;
      st_done      <= 1'b0;
      cnt          <= '0;
      step         <= '0;
      q7           <= 1'b0;
      q5           <= 1'b0;
      extra        <= 1'b0;
      to_cnt       <= '0;
`ifdef FLASH_PROG_ERASE_EN
      op           <= OP_PROG;
`endif
    end else begin
      flash_rst_n_ <= 1'b1;
      wb_ack_o     <= wb_ack_o ? 1'b0 : (wb_stb_i & wb_cyc_i);
      if (access) wb_dat_o <= rd_mux;
      if (wr_ok) begin
        case (wb_adr_i)
          REG_ADDR_LO: addr_r[15:0]  <= wb_dat_i;
          REG_ADDR_HI: addr_r[21:16] <= wb_dat_i[5:0];
          REG_DATA:    data_r        <= wb_dat_i;
          default: ;
        endcase
      end
      if (start) begin
        st_err  <= 1'b0;
        st_to   <= 1'b0;
        st_done <= 1'b0;
        step    <= '0;
        extra   <= 1'b0;
        to_cnt  <= '0;
`ifdef FLASH_PROG_ERASE_EN
        op      <= wb_dat_i[0] ? OP_PROG : OP_ERASE;
`endif
      end
      cnt <= (state_nx != state) ? '0 : cnt + 1'b1;
      if (state == S_W_HOLD && !rom_last) step <= step + 1'b1;
      if (state == S_P_READ && cnt == RD_LAST) begin
        q7 <= flash_data_i[7];
        q5 <= flash_data_i[5];
      end
      if (retry)    extra   <= 1'b1;
      if (to_inc)   to_cnt  <= to_cnt + 1'b1;
      if (fin_done) st_done <= 1'b1;
      if (fin_err)  st_err  <= 1'b1;
      if (fin_to)   st_to   <= 1'b1;
    end
  end

  always_comb begin
    flash_addr_   = addr_r;
    flash_data_o  = rom_data;
    flash_data_oe = 1'b0;
    flash_we_n_   = 1'b1;
    flash_oe_n_   = 1'b1;
    flash_ce_n_   = 1'b1;
    case (state)
      S_W_SETUP, S_W_HOLD: begin
        flash_ce_n_ = 1'b0; flash_addr_ = rom_addr; flash_data_oe = 1'b1;
      end
      S_W_PULSE: begin
        flash_ce_n_ = 1'b0; flash_addr_ = rom_addr; flash_data_oe = 1'b1;
        flash_we_n_ = 1'b0;
      end
      S_P_READ: begin flash_ce_n_ = 1'b0; flash_oe_n_ = 1'b0; end
      S_P_GAP:  flash_ce_n_ = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_prog.sv
// Bench for flash_prog: register table, program/erase/DQ5/timeout runs,
// busy lockout and mid-operation reset. Bus writes seen on the flash pins
// are compared against a queue of expected writes filled at command issue.
module tb_flash_prog;
  import flash_pkg::*;

  localparam int WE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic [2:1]  wb_adr_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [1:0]  wb_sel_i;
  logic        busy_o;
  logic [22:1] flash_addr_;
  logic [15:0] flash_data_i, flash_data_o;
  logic        flash_data_oe, flash_we_n_, flash_oe_n_, flash_ce_n_, flash_rst_n_;

  always #5 clk = ~clk;

  flash_prog #(.WE_CYCLES(WE), .RD_CYCLES(4), .TO_BITS(4)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .busy_o(busy_o),
    .flash_addr_(flash_addr_), .flash_data_i(flash_data_i), .flash_data_o(flash_data_o),
    .flash_data_oe(flash_data_oe), .flash_we_n_(flash_we_n_), .flash_oe_n_(flash_oe_n_),
    .flash_ce_n_(flash_ce_n_), .flash_rst_n_(flash_rst_n_)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // flash model: mode selects how poll reads answer
  int mode = 0;
  int poll_n = 0;
  int poll_base = 0;
  int rel;
  assign rel = poll_n - poll_base;
  always_comb begin
    case (mode)
      0:       flash_data_i = (rel >= 3) ? 16'hBEEF : 16'h4110;
      1:       flash_data_i = (rel > 10) ? 16'h0080 : 16'h0000;
      2:       flash_data_i = 16'h0020;
      default: flash_data_i = 16'h0000;
    endcase
  end

  typedef struct { logic [21:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];
  bit  mon_en = 1'b1;
  int  we_lo = 0;
  bit  oe_prev = 1'b1;

  always @(negedge clk) begin
    wr_t e;
    if (!mon_en) we_lo = 0;
    else if (!flash_we_n_) we_lo++;
    else if (we_lo > 0) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=%0h/%0h expected=none", flash_addr_, flash_data_o);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(flash_addr_), 32'(e.a));
        chk("wr_data", 32'(flash_data_o), 32'(e.d));
        chk("we_width", we_lo, WE);
        chk("wr_oe_hold", 32'(flash_data_oe), 1);
      end
      we_lo = 0;
    end
    if (!flash_oe_n_ && oe_prev) begin
      poll_n++;
      chk("poll_pads_released", 32'(flash_data_oe), 0);
    end
    oe_prev = flash_oe_n_;
  end

  task automatic wb_acc(input logic [1:0] a, input logic w, input logic [15:0] d,
                        output logic [15:0] r);
    int n;
    @(negedge clk);
    wb_adr_i = a; wb_we_i = w; wb_dat_i = d; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) chk("ack_timeout", 32'(wb_ack_o), 1);
    r = wb_dat_o;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    logic [15:0] r;
    wb_acc(a, 1'b1, d, r);
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] r);
    wb_acc(a, 1'b0, 16'h0000, r);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy_o && n < 1000) begin @(negedge clk); n++; end
    if (busy_o) chk(name, 32'(busy_o), 0);
  endtask

  task automatic push(input logic [21:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_prog(input logic [21:0] a, input logic [15:0] d);
    push(22'h555, 16'h00AA); push(22'h2AA, 16'h0055); push(22'h555, 16'h00A0); push(a, d);
  endtask

  task automatic run_poll(input int m, input int exp_polls, input logic [15:0] exp_st,
                          input string name);
    logic [15:0] r;
    wait_idle({name, "_idle"});
    chk({name, "_polls"}, poll_n - poll_base, exp_polls);
    rd(REG_CMD, r);
    chk({name, "_status"}, 32'(r), 32'(exp_st));
    chk({name, "_all_writes"}, exp_q.size(), 0);
    if (m < 0) chk("bad_mode", 1, 0);
  endtask

  typedef struct { logic [1:0] adr; logic we; logic [15:0] d; logic [15:0] exp; } vec_t;
  vec_t tbl[12];

  initial begin
    logic [15:0] r;
    logic [3:0]  pat;
    int n;
    rst = 1'b1; wb_dat_i = '0; wb_adr_i = '0; wb_we_i = 1'b0; wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0; wb_sel_i = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(wb_ack_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_flash_rst", 32'(flash_rst_n_), 0);
    chk("rst_we_n", 32'(flash_we_n_), 1);
    chk("rst_dat_o", 32'(wb_dat_o), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("flash_rst_release", 32'(flash_rst_n_), 1);

    tbl[0]  = '{REG_ADDR_LO, 1'b0, 16'h0000, 16'h0000};
    tbl[1]  = '{REG_ADDR_HI, 1'b0, 16'h0000, 16'h0000};
    tbl[2]  = '{REG_DATA,    1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{REG_CMD,     1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{REG_ADDR_LO, 1'b1, 16'h2345, 16'h0000};
    tbl[5]  = '{REG_ADDR_HI, 1'b1, 16'hFFFF, 16'h0000};
    tbl[6]  = '{REG_DATA,    1'b1, 16'hBEEF, 16'h0000};
    tbl[7]  = '{REG_ADDR_LO, 1'b0, 16'h0000, 16'h2345};
    tbl[8]  = '{REG_ADDR_HI, 1'b0, 16'h0000, 16'h003F};
    tbl[9]  = '{REG_DATA,    1'b0, 16'h0000, 16'hBEEF};
    tbl[10] = '{REG_CMD,     1'b1, 16'hFFFC, 16'h0000};
    tbl[11] = '{REG_CMD,     1'b0, 16'h0000, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      wb_acc(tbl[i].adr, tbl[i].we, tbl[i].d, r);
      if (!tbl[i].we) chk($sformatf("tbl%0d", i), 32'(r), 32'(tbl[i].exp));
    end
    chk("no_cmd_no_busy", 32'(busy_o), 0);

    // held strobe: ack alternates, never two in a row
    @(negedge clk);
    wb_adr_i = REG_ADDR_LO; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    pat = '0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pat = {pat[2:0], wb_ack_o}; end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    chk("ack_pattern", 32'(pat), 32'b1010);

    // program 0x012345 / BEEF, data returns on the 3rd poll
    wr(REG_ADDR_HI, 16'h0001);
    mode = 0; poll_base = poll_n;
    push_prog(22'h012345, 16'hBEEF);
    wr(REG_CMD, 16'h0001);
    n = 0;
    while (flash_oe_n_ && n < 100) begin @(negedge clk); n++; end
    chk("first_poll_latency", n, 4 * (WE + 2));
    run_poll(0, 3, 16'h0008, "prog");

    // busy lockout: DATA and CMD writes during a program are ignored
    poll_base = poll_n;
    push_prog(22'h012345, 16'hBEEF);
    wr(REG_CMD, 16'h0001);
    wr(REG_DATA, 16'h1111);
    wr(REG_CMD, 16'h0003);
    run_poll(0, 3, 16'h0008, "lock");
    rd(REG_DATA, r);
    chk("lock_data_kept", 32'(r), 32'hBEEF);
    repeat (4) @(negedge clk);
    chk("lock_no_restart", 32'(busy_o), 0);

    // DQ5 failure: one extra read then error
    wr(REG_DATA, 16'h00FF);
    mode = 2; poll_base = poll_n;
    push_prog(22'h012345, 16'h00FF);
    wr(REG_CMD, 16'h0001);
    run_poll(2, 2, 16'h0002, "dq5");

    // timeout with 4-bit counter: 15 polls
    mode = 3; poll_base = poll_n;
    push_prog(22'h012345, 16'h00FF);
    wr(REG_CMD, 16'h0001);
    run_poll(3, 15, 16'h0006, "timeout");

`ifdef FLASH_PROG_ERASE_EN
    wr(REG_ADDR_HI, 16'h0020);
    wr(REG_ADDR_LO, 16'h0000);
    mode = 1; poll_base = poll_n;
    push(22'h555, 16'h00AA); push(22'h2AA, 16'h0055); push(22'h555, 16'h0080);
    push(22'h555, 16'h00AA); push(22'h2AA, 16'h0055); push(22'h200000, 16'h0030);
    wr(REG_CMD, 16'h0002);
    run_poll(1, 11, 16'h0008, "erase");
`else
    wr(REG_CMD, 16'h0002);
    repeat (3) @(negedge clk);
    chk("erase_off_idle", 32'(busy_o), 0);
    rd(REG_CMD, r);
    chk("erase_off_status", 32'(r), 32'h0006);
`endif

    // reset during W_PULSE
    mon_en = 1'b0;
    mode = 0;
    wr(REG_CMD, 16'h0001);
    n = 0;
    while (flash_we_n_ && n < 50) begin @(negedge clk); n++; end
    chk("reach_w_pulse", 32'(flash_we_n_), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_we_n", 32'(flash_we_n_), 1);
    chk("rst_mid_oe", 32'(flash_data_oe), 0);
    chk("rst_mid_busy", 32'(busy_o), 0);
    chk("rst_mid_flash_rst", 32'(flash_rst_n_), 0);
    chk("rst_mid_ce_n", 32'(flash_ce_n_), 1);
    @(negedge clk); rst = 1'b0;
    rd(REG_CMD, r);
    chk("rst_mid_status", 32'(r), 0);
    rd(REG_DATA, r);
    chk("rst_mid_data", 32'(r), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
